prm_edge_query_seq: RTL and testbench
=====================================

Name: prm_edge_query_seq

Overview:
- Initiator side of the PRM obstacle-check interface: streams 15-bit obstacle codes (A..O ordering, A = bit 0) into an external combinational bank of edge checkers.
- Samples that bank's per-edge edge_mask bus and OR-accumulates it over one batch of obstacles.
- Returns a single blocked-edge word per batch to the roadmap builder.
- Sits between the obstacle-list reader (valid/ready source) and the roadmap builder (valid/ready sink).

Parameters:
- NUM_EDGE, 32, number of edge checkers in the bank (width of chk_mask and res_mask).
- CODE_W, 15, obstacle code width; must match checker inputs A..O.
- CNT_W, 16, width of the obstacle-count and processed-count fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a batch; sampled only in IDLE.
- num_obs  in  CNT_W  obstacle count for the batch; latched on start.
- obs_valid  in  1  obstacle code valid.
- obs_code  in  CODE_W  obstacle code.
- obs_ready  out  1  block accepts obstacle code.
- chk_code  out  CODE_W  registered code driven to the checker bank.
- chk_mask  in  NUM_EDGE  bank response (edge_mask per edge) to chk_code, combinational.
- res_valid  out  1  batch result valid.
- res_mask  out  NUM_EDGE  1 = edge blocked by at least one obstacle.
- res_count  out  CNT_W  number of obstacles processed.
- res_ready  in  1  result consumed.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; obs_ready=0, res_valid=0, busy=0, chk_code=0, res_mask=0, res_count=0; internal remaining=0, stage-1 valid v1=0, acc=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 latches remaining=num_obs, clears acc and the processed counter.
  - Next state is RUN, or DONE if num_obs=0 (DONE then presents res_mask=0, res_count=0).
  - start in any other state is ignored.
- RUN:
  - obs_ready=1 while remaining!=0.
  - A handshake (obs_valid&obs_ready) loads chk_code<=obs_code, sets v1=1, decrements remaining, increments processed.
  - A cycle with no handshake clears v1.
  - The accept that drives remaining to 0 moves the state to DRAIN; obs_ready drops the same cycle.
- Accumulate stage:
  - On every cycle where v1=1, acc<=acc|chk_mask.
  - chk_mask is sampled one cycle after the accept, i.e. the cycle in which chk_code holds that code.
  - Throughput is one obstacle per cycle.
- DRAIN: one cycle that absorbs the final v1 accumulate, then goes to DONE.
- DONE:
  - res_valid=1, res_mask=acc, res_count=processed; both held stable until res_ready=1.
  - The cycle res_valid&res_ready returns the state to IDLE and drops res_valid.
- Latency: res_valid rises 2 cycles after the final accept edge.
- chk_code holds its last value when idle; the bank output is ignored unless v1=1.
- obs_valid while obs_ready=0 has no effect; obs_code may change freely then.
- Counter width: num_obs up to 2^CNT_W-1; no wrap-around because remaining only decrements from the latched value.
- Reset mid-batch aborts immediately: no partial result is emitted, and the source must re-issue the batch.
- busy=1 in RUN, DRAIN and DONE.

Decomposition:
- Package prm_chk_pkg holds: CODE_W, the default NUM_EDGE, the state enum (IDLE/RUN/DRAIN/DONE), and a typedef for the obstacle code.
- Sub-module prm_chk_bank sits alongside at the top level, not inside this block. It instantiates NUM_EDGE edge-check modules on a shared code bus and concatenates their edge_mask outputs into chk_mask.

Test Plan:
- Reset mid-RUN:
  - Stimulus: rst=1 with remaining=2.
  - Required: all outputs zero immediately; no res_valid afterwards; a fresh start with num_obs=1 completes normally.
- Basic batch:
  - Stimulus: num_obs=3, codes 0x1234, 0x0001, 0x7FFF back-to-back; bank model returns 0x00000005, 0x00000100, 0x00000000.
  - Required: res_mask=0x00000105, res_count=3, res_valid 2 cycles after the third accept.
- Gapped source:
  - Stimulus: num_obs=2, obs_valid low for 3 cycles between codes.
  - Required: no spurious accumulate during the gap (bank model returns 0xFFFFFFFF while v1=0); the result equals the OR of the two sampled masks only.
- Zero batch:
  - Stimulus: num_obs=0.
  - Required: res_valid next cycle with res_mask=0, res_count=0; obs_ready never asserted.
- Backpressure:
  - Stimulus: res_ready low for 5 cycles, plus a start pulse during DONE.
  - Required: res_mask and res_count stable; start ignored; IDLE reached one cycle after res_ready=1.

Source files
------------

// File: rtl/prm_chk_pkg.sv
// Shared types and constants for the PRM obstacle-check initiator.
// Holds the obstacle code width (checker inputs A..O, A = bit 0), the default
// checker-bank width, the obstacle code typedef and the sequencer state enum.
package prm_chk_pkg;

  localparam int CODE_W       = 15;
  localparam int NUM_EDGE_DEF = 32;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/prm_edge_query_seq_if.sv
// Obstacle stream (valid/ready in) and batch result (valid/ready out) bundle.
// slave  : the sequencer side (sinks obstacles, sources the result).
// master : the obstacle-list reader / roadmap builder side.
interface prm_edge_query_seq_if #(
  parameter int NUM_EDGE = prm_chk_pkg::NUM_EDGE_DEF,
  parameter int CNT_W    = 16
);
  import prm_chk_pkg::*;

  logic                obs_valid;
  code_t               obs_code;
  logic                obs_ready;
  logic                res_valid;
  logic [NUM_EDGE-1:0] res_mask;
  logic [CNT_W-1:0]    res_count;
  logic                res_ready;

  modport slave (
    input  obs_valid, obs_code, res_ready,
    output obs_ready, res_valid, res_mask, res_count
  );

  modport master (
    output obs_valid, obs_code, res_ready,
    input  obs_ready, res_valid, res_mask, res_count
  );

endinterface

// File: rtl/prm_edge_query_seq_acc.sv
// Check stage: registers the accepted code onto the checker bus and ORs the
// bank response into the blocked-edge accumulator one cycle later.
// Ports: accept_i/code_i (accepted obstacle), clr_i (batch start),
//        chk_mask_i (bank response), chk_code_o (to bank), acc_o (accumulator).
module prm_edge_query_seq_acc
  import prm_chk_pkg::*;
#(
  parameter int NUM_EDGE = NUM_EDGE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accept_i,
  input  logic                clr_i,
  input  code_t               code_i,
  input  logic [NUM_EDGE-1:0] chk_mask_i,
  output code_t               chk_code_o,
  output logic [NUM_EDGE-1:0] acc_o
);

  code_t               chk_code_q;
  logic                v1_q;
  logic [NUM_EDGE-1:0] acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_code_q <= '0;
      v1_q       <= 1'b0;
      acc_q      <= '0;
    end else begin
      // v1 marks the cycle in which chk_code holds a freshly accepted code;
      // outside that cycle the bank output is meaningless and is ignored.
      v1_q <= accept_i;
      if (accept_i) chk_code_q <= code_i;
      // clr only occurs in IDLE, where v1 is always low, so no overlap.
      if (clr_i)     acc_q <= '0;
      else if (v1_q) acc_q <= acc_q | chk_mask_i;
    end
  end

  assign chk_code_o = chk_code_q;
  assign acc_o      = acc_q;

endmodule

// File: rtl/prm_edge_query_seq.sv
// Initiator of the PRM obstacle check: streams a batch of obstacle codes into
// an external combinational checker bank and returns the OR of its edge masks.
// Latency: result valid 2 cycles after the cycle of the final accept; one
// obstacle per cycle. Backpressure: obs_ready only in RUN with codes pending;
// the result is held stable in DONE until res_ready.
// Ports: clk, rst (async, active high), start/num_obs (batch launch),
//        bus (obstacle stream + result), chk_code/chk_mask (checker bank), busy.
module prm_edge_query_seq
  import prm_chk_pkg::*;
#(
  parameter int NUM_EDGE = NUM_EDGE_DEF,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_obs,
  prm_edge_query_seq_if.slave  bus,
  output code_t                chk_code,
  input  logic [NUM_EDGE-1:0]  chk_mask,
  output logic                 busy
);

  state_e              state_q;
  logic [CNT_W-1:0]    remaining_q;
  logic [CNT_W-1:0]    processed_q;
  logic                obs_ready_q;
  logic                res_valid_q;
  logic                busy_q;
  logic                accept;
  logic                clr;
  logic [NUM_EDGE-1:0] acc;

  assign accept = bus.obs_valid & obs_ready_q;
  assign clr    = (state_q == IDLE) & start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      processed_q <= '0;
      obs_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            remaining_q <= num_obs;
            processed_q <= '0;
            busy_q      <= 1'b1;
            if (num_obs == '0) begin
              state_q     <= DONE;
              res_valid_q <= 1'b1;
            end else begin
              state_q     <= RUN;
              obs_ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            remaining_q <= remaining_q - CNT_W'(1);
            processed_q <= processed_q + CNT_W'(1);
            // Last code: ready drops at this same edge so no extra accept.
            if (remaining_q == CNT_W'(1)) begin
              state_q     <= DRAIN;
              obs_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // The final code's mask is absorbed at this edge.
          state_q     <= DONE;
          res_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  prm_edge_query_seq_acc #(.NUM_EDGE(NUM_EDGE)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .accept_i   (accept),
    .clr_i      (clr),
    .code_i     (bus.obs_code),
    .chk_mask_i (chk_mask),
    .chk_code_o (chk_code),
    .acc_o      (acc)
  );

  assign bus.obs_ready = obs_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_mask  = acc;
  assign bus.res_count = processed_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// Bench for prm_edge_query_seq: a lookup-table checker bank that returns
// all-ones outside the sample cycle, a vector table of batches, and
// hand-written reset, backpressure and ignored-start sequences.
module tb_prm_edge_query_seq;
  import prm_chk_pkg::*;

  localparam int NE = NUM_EDGE_DEF;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_obs;
  code_t         chk_code;
  logic [NE-1:0] chk_mask;
  logic          busy;

  prm_edge_query_seq_if #(.NUM_EDGE(NE), .CNT_W(CW)) bus ();

  prm_edge_query_seq #(.NUM_EDGE(NE), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_obs  (num_obs),
    .bus      (bus.slave),
    .chk_code (chk_code),
    .chk_mask (chk_mask),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Checker bank model: valid only in the cycle after an accept.
  function automatic logic [31:0] bank(input code_t c);
    case (c)
      15'h1234: return 32'h0000_0005;
      15'h0001: return 32'h0000_0100;
      15'h7FFF: return 32'h0000_0000;
      15'h0010: return 32'h0000_00F0;
      15'h0200: return 32'h8000_0000;
      default:  return {17'd0, c};
    endcase
  endfunction

  logic tb_v1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tb_v1 <= 1'b0;
    else     tb_v1 <= bus.obs_valid & bus.obs_ready;
  end
  always_comb chk_mask = tb_v1 ? bank(chk_code) : 32'hFFFF_FFFF;

  typedef struct {
    logic [CW-1:0]    n;
    logic [3:0][14:0] codes;   // codes[0] is sent first
    int               gap;
    logic [31:0]      exp_mask;
    logic [CW-1:0]    exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic run_batch(input logic [CW-1:0] n, input logic [3:0][14:0] codes,
                           input int gap, input logic [31:0] em, input logic [CW-1:0] ec);
    @(negedge clk);
    start   = 1'b1;
    num_obs = n;
    @(negedge clk);
    start   = 1'b0;
    num_obs = 16'hBEEF;
    if (n == '0) begin
      check("zero_obs_ready", 32'(bus.obs_ready), 32'd0);
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        int budget;
        budget        = 0;
        bus.obs_valid = 1'b1;
        bus.obs_code  = codes[i];
        while (!bus.obs_ready && budget < 20) begin
          @(negedge clk);
          budget++;
        end
        check("obs_ready_wait", 32'(bus.obs_ready), 32'd1);
        @(negedge clk);
        check("chk_code", 32'(chk_code), 32'(codes[i]));
        bus.obs_valid = 1'b0;
        bus.obs_code  = ~codes[i];
        if (i < int'(n) - 1) repeat (gap) @(negedge clk);
      end
      // DRAIN cycle
      check("drain_res_valid", 32'(bus.res_valid), 32'd0);
      check("drain_obs_ready", 32'(bus.obs_ready), 32'd0);
      @(negedge clk);
    end
    check("res_valid", 32'(bus.res_valid), 32'd1);
    check("res_mask", bus.res_mask, em);
    check("res_count", 32'(bus.res_count), 32'(ec));
    check("busy_done", 32'(busy), 32'd1);
  endtask

  task automatic release_result();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("idle_res_valid", 32'(bus.res_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst           = 1'b1;
    start         = 1'b0;
    num_obs       = '0;
    bus.obs_valid = 1'b0;
    bus.obs_code  = '0;
    bus.res_ready = 1'b0;

    vecs[0] = '{16'd3, {15'h0000, 15'h7FFF, 15'h0001, 15'h1234}, 0, 32'h0000_0105, 16'd3};
    vecs[1] = '{16'd2, {15'h0000, 15'h0000, 15'h0200, 15'h0010}, 3, 32'h8000_00F0, 16'd2};
    vecs[2] = '{16'd0, {15'h0000, 15'h0000, 15'h0000, 15'h0000}, 0, 32'h0000_0000, 16'd0};
    vecs[3] = '{16'd1, {15'h0000, 15'h0000, 15'h0000, 15'h7FFF}, 0, 32'h0000_0000, 16'd1};
    vecs[4] = '{16'd4, {15'h1234, 15'h0200, 15'h0010, 15'h0001}, 1, 32'h8000_01F5, 16'd4};

    #2;
    check("rst_obs_ready", 32'(bus.obs_ready), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_chk_code", 32'(chk_code), 32'd0);
    check("rst_res_mask", bus.res_mask, 32'd0);
    check("rst_res_count", 32'(bus.res_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_batch(vecs[v].n, vecs[v].codes, vecs[v].gap, vecs[v].exp_mask, vecs[v].exp_cnt);
      release_result();
    end

    // Reset with two codes still pending.
    @(negedge clk);
    start   = 1'b1;
    num_obs = 16'd3;
    @(negedge clk);
    start         = 1'b0;
    bus.obs_valid = 1'b1;
    bus.obs_code  = 15'h1234;
    @(negedge clk);
    bus.obs_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_obs_ready", 32'(bus.obs_ready), 32'd0);
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_chk_code", 32'(chk_code), 32'd0);
    check("midrst_res_mask", bus.res_mask, 32'd0);
    check("midrst_res_count", 32'(bus.res_count), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus.res_valid | busy;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    run_batch(16'd1, {15'h0, 15'h0, 15'h0, 15'h0042}, 0, 32'h0000_0042, 16'd1);
    release_result();

    // Result backpressure with a start pulse arriving in DONE.
    run_batch(16'd2, {15'h0, 15'h0, 15'h0001, 15'h1234}, 0, 32'h0000_0105, 16'd2);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        start   = 1'b1;
        num_obs = 16'd7;
      end
      @(negedge clk);
      start = 1'b0;
      check("bp_res_valid", 32'(bus.res_valid), 32'd1);
      check("bp_res_mask", bus.res_mask, 32'h0000_0105);
      check("bp_res_count", 32'(bus.res_count), 32'd2);
    end
    release_result();
    @(negedge clk);
    check("bp_start_ignored_ready", 32'(bus.obs_ready), 32'd0);
    check("bp_start_ignored_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
